// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// default bus address and bit-counter width.
package i2c_target_pkg;

  localparam logic [6:0] TARGET_ADDR_DEFAULT = 7'h2A;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with registered edge, START and STOP detection.
// All outputs are aligned: sda_s is the SDA value seen alongside each pulse.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_h;
  logic                   sda_h;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];
  assign sda_s   = sda_h;

  // Synchronisers reset to the idle-bus level so reset release sees no START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_h     <= 1'b1;
      sda_h     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_h     <= scl_now;
      sda_h     <= sda_now;
      scl_rise  <= scl_now & ~scl_h;
      scl_fall  <= ~scl_now & scl_h;
      start_det <= scl_now & scl_h & sda_h & ~sda_now;
      stop_det  <= scl_now & scl_h & ~sda_h & sda_now;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, multi-byte write to rx_data, multi-byte read
// from tx_data, open-drain SDA driver. Never stretches SCL.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = TARGET_ADDR_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  logic       sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy
);

  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic             sda_s;
  state_t           state;
  logic [7:0]       shifter;
  logic [CNT_W-1:0] bitcnt;
  logic             rw;
  logic             ack_seen;
  logic             sda_oe;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  assign sda  = sda_oe ? 1'b0 : 1'bz;
  assign busy = (state != ST_IDLE);

  // In the ACK states sda_oe doubles as the phase flag: the first SCL fall
  // starts driving the ACK, the second one ends the ACK bit.
  // In TX the shifter holds the bits still to send, MSB already on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shifter  <= '0;
      bitcnt   <= '1;
      rw       <= 1'b0;
      ack_seen <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      addr_hit <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state    <= ST_IDLE;
        sda_oe   <= 1'b0;
        addr_hit <= 1'b0;
        ack_seen <= 1'b0;
      end else if (start_det) begin
        state    <= ST_ADDR;
        bitcnt   <= '1;
        shifter  <= '0;
        sda_oe   <= 1'b0;
        addr_hit <= 1'b0;
        ack_seen <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shifter <= {shifter[6:0], sda_s};
              if (bitcnt == '0) begin
                if (shifter[6:0] == TARGET_ADDR) begin
                  rw    <= sda_s;
                  state <= ST_ADDR_ACK;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end else begin
                bitcnt <= bitcnt - 1'b1;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe   <= 1'b1;
                addr_hit <= 1'b1;
              end else if (rw) begin
                tx_req  <= 1'b1;
                shifter <= {tx_data[6:0], 1'b0};
                sda_oe  <= ~tx_data[7];
                bitcnt  <= '1;
                state   <= ST_TX;
              end else begin
                sda_oe <= 1'b0;
                bitcnt <= '1;
                state  <= ST_RX;
              end
            end
          end
          ST_RX: begin
            if (scl_rise) begin
              shifter <= {shifter[6:0], sda_s};
              if (bitcnt == '0) begin
                rx_data  <= {shifter[6:0], sda_s};
                rx_valid <= 1'b1;
                state    <= ST_RX_ACK;
              end else begin
                bitcnt <= bitcnt - 1'b1;
              end
            end
          end
          ST_RX_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                bitcnt <= '1;
                state  <= ST_RX;
              end
            end
          end
          ST_TX: begin
            if (scl_fall) begin
              if (bitcnt == '0) begin
                sda_oe <= 1'b0;
                state  <= ST_TX_ACK;
              end else begin
                sda_oe  <= ~shifter[7];
                shifter <= {shifter[6:0], 1'b0};
                bitcnt  <= bitcnt - 1'b1;
              end
            end
          end
          ST_TX_ACK: begin
            // ACK is sampled on the rise; the next byte is loaded on the
            // following fall so SDA only changes while SCL is low.
            if (scl_rise) begin
              if (sda_s) begin
                state <= ST_WAIT_STOP;
              end else begin
                ack_seen <= 1'b1;
              end
            end else if (scl_fall && ack_seen) begin
              ack_seen <= 1'b0;
              tx_req   <= 1'b1;
              shifter  <= {tx_data[6:0], 1'b0};
              sda_oe   <= ~tx_data[7];
              bitcnt   <= '1;
              state    <= ST_TX;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-controller model, vector table of
// single-byte transactions, plus multi-byte read, repeated START and reset cases.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda_low;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_target #(
    .TARGET_ADDR(7'h2A),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda_bus),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .addr_hit(addr_hit),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int rx_cnt = 0;
  int tx_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) rx_cnt++;
    if (tx_req)   tx_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    m_sda_low = ~b;
    #50 scl = 1'b1;
    #50 seen = sda_bus;
    #50 scl = 1'b0;
    #50;
  endtask

  task automatic start_cond();
    m_sda_low = 1'b0;
    #50 scl = 1'b1;
    #50 m_sda_low = 1'b1;
    #50 scl = 1'b0;
    #50;
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1;
    #50 scl = 1'b1;
    #50 m_sda_low = 1'b0;
    #100;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] v);
    logic bit_v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, bit_v);
      v = {v[6:0], bit_v};
      if (i == 0) tx_data = next_tx;
    end
    clock_bit(nack, bit_v);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       exp_aack;
    logic [7:0] exp_byte;
    logic [7:0] exp_rx;
    logic [7:0] exp_rx_inc;
    logic [7:0] exp_tx_inc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vec_t       v;
    logic       ack;
    logic [7:0] got;
    int         r0;
    int         t0;
    logic       bit_v;

    vecs[0] = '{7'h2A, 1'b0, 8'hA5, 1'b0, 8'h00, 8'hA5, 8'd1, 8'd0};
    vecs[1] = '{7'h2B, 1'b0, 8'h77, 1'b1, 8'h01, 8'hA5, 8'd0, 8'd0};
    vecs[2] = '{7'h2A, 1'b1, 8'h3C, 1'b0, 8'h3C, 8'hA5, 8'd0, 8'd1};
    vecs[3] = '{7'h2A, 1'b0, 8'hFF, 1'b0, 8'h00, 8'hFF, 8'd1, 8'd0};
    vecs[4] = '{7'h2A, 1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 8'd0, 8'd1};
    vecs[5] = '{7'h55, 1'b1, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'd0, 8'd0};

    rst = 1'b1;
    scl = 1'b1;
    m_sda_low = 1'b0;
    tx_data = 8'h00;
    #20;
    check("rst_sda", {7'b0, sda_bus}, 8'h01);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", {7'b0, rx_valid}, 8'h00);
    check("rst_tx_req", {7'b0, tx_req}, 8'h00);
    check("rst_addr_hit", {7'b0, addr_hit}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    #20 rst = 1'b0;
    #100;

    for (int i = 0; i < 6; i++) begin
      v  = vecs[i];
      r0 = rx_cnt;
      t0 = tx_cnt;
      if (v.rw) tx_data = v.data;
      start_cond();
      write_byte({v.addr, v.rw}, ack);
      check($sformatf("v%0d_addr_ack", i), {7'b0, ack}, {7'b0, v.exp_aack});
      check($sformatf("v%0d_addr_hit", i), {7'b0, addr_hit}, {7'b0, ~v.exp_aack});
      if (v.rw) begin
        read_byte(1'b1, v.data, got);
      end else begin
        write_byte(v.data, ack);
        got = {7'b0, ack};
      end
      check($sformatf("v%0d_data", i), got, v.exp_byte);
      check($sformatf("v%0d_busy_pre_stop", i), {7'b0, busy}, 8'h01);
      stop_cond();
      check($sformatf("v%0d_rx_data", i), rx_data, v.exp_rx);
      check($sformatf("v%0d_rx_pulses", i), 8'(rx_cnt - r0), v.exp_rx_inc);
      check($sformatf("v%0d_tx_pulses", i), 8'(tx_cnt - t0), v.exp_tx_inc);
      check($sformatf("v%0d_busy_idle", i), {7'b0, busy}, 8'h00);
      check($sformatf("v%0d_addr_hit_idle", i), {7'b0, addr_hit}, 8'h00);
    end

    // Two-byte read: ACK first byte, NACK second
    t0 = tx_cnt;
    tx_data = 8'h3C;
    start_cond();
    write_byte({7'h2A, 1'b1}, ack);
    check("mb_addr_ack", {7'b0, ack}, 8'h00);
    read_byte(1'b0, 8'hC3, got);
    check("mb_byte0", got, 8'h3C);
    check("mb_tx_req_after_ack", 8'(tx_cnt - t0), 8'd2);
    read_byte(1'b1, 8'hC3, got);
    check("mb_byte1", got, 8'hC3);
    stop_cond();
    check("mb_tx_pulses", 8'(tx_cnt - t0), 8'd2);
    check("mb_busy_idle", {7'b0, busy}, 8'h00);

    // Repeated START after four data bits of a write
    r0 = rx_cnt;
    t0 = tx_cnt;
    start_cond();
    write_byte({7'h2A, 1'b0}, ack);
    check("rs_addr_ack", {7'b0, ack}, 8'h00);
    clock_bit(1'b1, bit_v);
    clock_bit(1'b0, bit_v);
    clock_bit(1'b1, bit_v);
    clock_bit(1'b0, bit_v);
    tx_data = 8'h5C;
    start_cond();
    write_byte({7'h2A, 1'b1}, ack);
    check("rs_read_addr_ack", {7'b0, ack}, 8'h00);
    read_byte(1'b1, 8'h5C, got);
    check("rs_read_byte", got, 8'h5C);
    stop_cond();
    check("rs_rx_pulses", 8'(rx_cnt - r0), 8'd0);
    check("rs_rx_data_kept", rx_data, 8'hFF);
    check("rs_tx_pulses", 8'(tx_cnt - t0), 8'd1);

    // Reset while the target drives the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) clock_bit(((8'h54 >> i) & 8'h01) != 8'h00, bit_v);
    m_sda_low = 1'b0;
    check("ra_ack_driven", {7'b0, sda_bus}, 8'h00);
    check("ra_addr_hit", {7'b0, addr_hit}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("ra_sda_released", {7'b0, sda_bus}, 8'h01);
    check("ra_rx_data", rx_data, 8'h00);
    check("ra_addr_hit_clr", {7'b0, addr_hit}, 8'h00);
    check("ra_busy", {7'b0, busy}, 8'h00);
    check("ra_rx_valid", {7'b0, rx_valid}, 8'h00);
    check("ra_tx_req", {7'b0, tx_req}, 8'h00);
    #7 rst = 1'b0;
    stop_cond();
    r0 = rx_cnt;
    start_cond();
    write_byte({7'h2A, 1'b0}, ack);
    check("ra_addr_ack2", {7'b0, ack}, 8'h00);
    write_byte(8'h5A, ack);
    check("ra_data_ack", {7'b0, ack}, 8'h00);
    stop_cond();
    check("ra_rx_data2", rx_data, 8'h5A);
    check("ra_rx_pulses", 8'(rx_cnt - r0), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
